// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared Game-of-Life board geometry and reader state encoding
package life_pkg;

  localparam int ROWS    = 16;
  localparam int COLS    = 16;
  localparam int BOARD_W = ROWS * COLS;
  localparam int IDX_W   = $clog2(ROWS);
  localparam int POP_W   = $clog2(BOARD_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } reader_state_e;

endpackage

// File: rtl/row_popcount.sv
// rtl/row_popcount.sv - combinational live-cell count of one board row
module row_popcount #(
  parameter  int W  = 16,
  localparam int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  row,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(row[i]);
    end
  end

endmodule

// File: rtl/life_board_reader.sv
// rtl/life_board_reader.sv - snapshots the life board and streams it row by row,
// then publishes the live-cell population of that snapshot
module life_board_reader
  import life_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ROWS*COLS-1:0]                  board,
  input  logic                                  snap_req,
  output logic                                  busy,
  output logic [COLS-1:0]                       row_data,
  output logic [$clog2(ROWS)-1:0]               row_idx,
  output logic                                  row_last,
  output logic                                  row_valid,
  input  logic                                  row_ready,
  output logic [$clog2(ROWS*COLS+1)-1:0]        pop_total,
  output logic                                  pop_valid
);

  localparam int BW  = ROWS * COLS;
  localparam int IW  = $clog2(ROWS);
  localparam int PW  = $clog2(BW + 1);
  localparam int CW  = $clog2(COLS + 1);

  reader_state_e state_q, state_d;
  logic [BW-1:0] shadow_q, shadow_d;
  logic [IW-1:0] row_idx_q, row_idx_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] pop_total_q, pop_total_d;
  logic          pop_valid_q, pop_valid_d;
  logic          busy_q, busy_d;
  logic          row_valid_q, row_valid_d;
  logic          row_last_q, row_last_d;
  logic [CW-1:0] row_cnt;
  logic          beat_acc;

  // Rows come from the shadow copy so the engine may keep stepping underneath.
  assign row_data = shadow_q[row_idx_q*COLS +: COLS];
  assign beat_acc = row_valid_q & row_ready;

  row_popcount #(.W(COLS)) u_row_popcount (
    .row   (row_data),
    .count (row_cnt)
  );

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    row_idx_d   = row_idx_q;
    acc_d       = acc_q;
    pop_total_d = pop_total_q;
    pop_valid_d = 1'b0;
    busy_d      = busy_q;
    row_valid_d = row_valid_q;
    row_last_d  = row_last_q;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          shadow_d    = board;
          row_idx_d   = '0;
          acc_d       = '0;
          busy_d      = 1'b1;
          row_valid_d = 1'b1;
          row_last_d  = (ROWS == 1);
          state_d     = SEND;
        end
      end
      SEND: begin
        if (beat_acc) begin
          acc_d = acc_q + PW'(row_cnt);
          if (row_idx_q == IW'(ROWS - 1)) begin
            // Index stays on the last row; it only returns to 0 on the next capture.
            pop_total_d = acc_d;
            pop_valid_d = 1'b1;
            row_valid_d = 1'b0;
            row_last_d  = 1'b0;
            state_d     = DONE;
          end else begin
            row_idx_d  = row_idx_q + IW'(1);
            row_last_d = (row_idx_q == IW'(ROWS - 2));
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        row_valid_d = 1'b0;
        row_last_d  = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shadow_q    <= '0;
      row_idx_q   <= '0;
      acc_q       <= '0;
      pop_total_q <= '0;
      pop_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      row_idx_q   <= row_idx_d;
      acc_q       <= acc_d;
      pop_total_q <= pop_total_d;
      pop_valid_q <= pop_valid_d;
      busy_q      <= busy_d;
      row_valid_q <= row_valid_d;
      row_last_q  <= row_last_d;
    end
  end

  assign busy      = busy_q;
  assign row_idx   = row_idx_q;
  assign row_last  = row_last_q;
  assign row_valid = row_valid_q;
  assign pop_total = pop_total_q;
  assign pop_valid = pop_valid_q;

endmodule
